// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: selects one of NUM_IN packed operands and pushes the
// result, tagged with an out-of-range flag, into a 2-entry skid buffer.
// In_ready_ comes purely from registered buffer state, so downstream
// backpressure never ripples combinationally into the upstream handshake.
module operand_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_,
    input  logic                    rst_n_,
    input  logic [NUM_IN*WIDTH-1:0] Inp_,
    input  logic [SEL_W-1:0]        Sel_,
    input  logic                    Lock_,
    input  logic                    In_valid_,
    output logic                    In_ready_,
    output logic [WIDTH-1:0]        Out_,
    output logic                    Out_err_,
    output logic                    Out_valid_,
    input  logic                    Out_ready_,
    output logic [7:0]              Err_cnt_
);

    // Buffer occupancy states
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W+1)'(NUM_IN);

    logic [1:0]       state;
    logic             armed;      // low until the first clock edge after reset release
    logic [SEL_W-1:0] lock_sel;
    logic [SEL_W-1:0] eff_sel;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic [WIDTH:0]   new_entry;  // {data, err}
    logic [WIDTH:0]   head_q;
    logic [WIDTH:0]   tail_q;
    logic [7:0]       err_cnt;
    logic             accept;
    logic             pop;

    assign In_ready_  = (state != FULL);
    assign Out_valid_ = (state != EMPTY);
    assign accept     = In_valid_ & In_ready_ & armed;
    assign pop        = Out_valid_ & Out_ready_;
    assign eff_sel    = Lock_ ? lock_sel : Sel_;
    assign new_entry  = {sel_data, sel_err};
    assign Out_       = head_q[WIDTH:1];
    assign Out_err_   = head_q[0];
    assign Err_cnt_   = err_cnt;

    // Operand select; an out-of-range select yields zero data and the error flag
    always_comb begin
        // NOTE: default every output of a combinational block first so no path leaves it unassigned (no latch).
        sel_data = '0;
        sel_err  = ({1'b0, eff_sel} >= NUM_IN_EXT);
        for (int k = 0; k < NUM_IN; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                sel_data = Inp_[k*WIDTH +: WIDTH];
            end
        end
    end

    // Skid buffer occupancy and entry storage; the newest entry goes to head
    // whenever the head is leaving in the same cycle
    always_ff @(posedge clk_ or negedge rst_n_) begin
        // NOTE: entries are reset too, so Out_ reads zero during and after reset rather than stale data.
        if (!rst_n_) begin
            state  <= EMPTY;
            armed  <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            armed <= 1'b1;
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_q <= new_entry;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_q <= new_entry;
                    end else if (accept) begin
                        tail_q <= new_entry;
                        state  <= FULL;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q <= tail_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Locked select follows Sel_ on every unlocked accept and freezes while locked
    always_ff @(posedge clk_ or negedge rst_n_) begin
        if (!rst_n_) begin
            lock_sel <= '0;
        end else if (accept && !Lock_) begin
            lock_sel <= Sel_;
        end
    end

    // Saturating count of accepted out-of-range transactions
    always_ff @(posedge clk_ or negedge rst_n_) begin
        if (!rst_n_) begin
            err_cnt <= '0;
        end else if (accept && sel_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
